// File: rtl/matrix_ops_pkg.sv
// Shared helpers for the packed-matrix blocks: FSM state encoding,
// index-width helper and element offset within a flat matrix word.
package matrix_ops_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Index widths never drop below 1 bit, even for single-row/column matrices.
    function automatic int clog2_min2(input int v);
        int r;
        int x;
        r = 0;
        x = (v < 2) ? 2 : v;
        while ((1 << r) < x) r++;
        return r;
    endfunction

    function automatic int elem_offset(input int r, input int c, input int n, input int w);
        return (r * n + c) * w;
    endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// 2-D row/column counter with enable, wrap and look-ahead of the next index.
// Order is row-major unless MATRIX_STREAM_TRANSPOSE_EN is defined (column-major).
module matrix_index_counter #(
    parameter int MATRIX_SIZE_M = 3,
    parameter int MATRIX_SIZE_N = 2,
    parameter int RW            = 2,
    parameter int CW            = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [RW-1:0] row_o,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] nxt_row_o,
    output logic [CW-1:0] nxt_col_o,
    output logic          nxt_tc_o
);

    localparam logic [RW-1:0] ROW_MAX = RW'(MATRIX_SIZE_M - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(MATRIX_SIZE_N - 1);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    // row_d/col_d are the index that follows the current one, used on enable.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
`ifdef MATRIX_STREAM_TRANSPOSE_EN
        if (row_q == ROW_MAX) begin
            row_d = '0;
            col_d = (col_q == COL_MAX) ? '0 : col_q + 1'b1;
        end else begin
            row_d = row_q + 1'b1;
        end
`else
        if (col_q == COL_MAX) begin
            col_d = '0;
            row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
        end else begin
            col_d = col_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            row_q <= '0;
            col_q <= '0;
        end else if (en_i) begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o     = row_q;
    assign col_o     = col_q;
    assign nxt_row_o = row_d;
    assign nxt_col_o = col_d;
    assign nxt_tc_o  = (row_d == ROW_MAX) && (col_d == COL_MAX);

endmodule

// File: rtl/matrix_stream_tx.sv
// Captures a flat M x N matrix and streams it one element per valid/ready beat.
// Define MATRIX_STREAM_TRANSPOSE_EN to stream in column-major (transposed) order.
module matrix_stream_tx
    import matrix_ops_pkg::*;
#(
    parameter  int MATRIX_SIZE_M = 3,
    parameter  int MATRIX_SIZE_N = 2,
    parameter  int DATA_WIDTH    = 16,
    localparam int RW            = clog2_min2(MATRIX_SIZE_M),
    localparam int CW            = clog2_min2(MATRIX_SIZE_N),
    localparam int NE            = MATRIX_SIZE_M * MATRIX_SIZE_N,
    localparam int FLAT_W        = NE * DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [FLAT_W-1:0]     i_matrix,
    output logic                  o_busy,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [RW-1:0]         o_row,
    output logic [CW-1:0]         o_col,
    output logic                  o_last,
    output logic                  o_done
);

    localparam int IW = clog2_min2(NE);

    state_e                state_q, state_d;
    logic [FLAT_W-1:0]     cap_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  last_q;
    logic                  done_q;

    logic                  load_acc;
    logic                  hs;
    logic                  hs_last;
    logic [RW-1:0]         nxt_row;
    logic [CW-1:0]         nxt_col;
    logic                  nxt_tc;
    logic [IW-1:0]         nxt_idx;
    logic [DATA_WIDTH-1:0] elem_w [NE];

    assign load_acc = (state_q == ST_IDLE) && i_load;
    assign hs       = (state_q == ST_SEND) && i_ready;
    assign hs_last  = hs && last_q;

    for (genvar k = 0; k < NE; k++) begin : g_elem
        assign elem_w[k] = cap_q[elem_offset(k / MATRIX_SIZE_N, k % MATRIX_SIZE_N,
                                             MATRIX_SIZE_N, DATA_WIDTH) +: DATA_WIDTH];
    end

    assign nxt_idx = IW'(int'(nxt_row) * MATRIX_SIZE_N + int'(nxt_col));

    matrix_index_counter #(
        .MATRIX_SIZE_M(MATRIX_SIZE_M),
        .MATRIX_SIZE_N(MATRIX_SIZE_N),
        .RW           (RW),
        .CW           (CW)
    ) u_idx (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .clr_i    (load_acc),
        .en_i     (hs),
        .row_o    (o_row),
        .col_o    (o_col),
        .nxt_row_o(nxt_row),
        .nxt_col_o(nxt_col),
        .nxt_tc_o (nxt_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_load)  state_d = ST_SEND;
            ST_SEND: if (hs_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Beat registers look one index ahead so the next element is ready on handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cap_q  <= '0;
            data_q <= '0;
            last_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= hs_last;
            if (load_acc) begin
                cap_q  <= i_matrix;
                data_q <= i_matrix[DATA_WIDTH-1:0];
                last_q <= (NE == 1);
            end else if (hs) begin
                data_q <= elem_w[nxt_idx];
                last_q <= nxt_tc && !last_q;
            end
        end
    end

    assign o_busy  = (state_q == ST_SEND);
    assign o_valid = (state_q == ST_SEND);
    assign o_data  = data_q;
    assign o_last  = last_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_matrix_stream_tx.sv
// Self-checking bench for matrix_stream_tx (3x2 instance plus a 1x1 instance).
module tb_matrix_stream_tx;

    localparam int M    = 3;
    localparam int N    = 2;
    localparam int W    = 16;
    localparam int FLAT = M * N * W;

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   row;
        logic [0:0]   col;
        logic         last;
    } beat_t;

    typedef struct {
        logic [FLAT-1:0] mat;
        int              mode;
        bit              ghost;
        bit              chain;
        int              exp_cyc;
        logic [W-1:0]    exp_first;
        logic [W-1:0]    exp_last;
    } vec_t;

    logic            clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_load = 1'b0;
    logic [FLAT-1:0] i_matrix = '0;
    logic            i_ready = 1'b0;
    logic            o_busy, o_valid, o_last, o_done;
    logic [W-1:0]    o_data;
    logic [1:0]      o_row;
    logic [0:0]      o_col;

    logic            i1_load = 1'b0;
    logic [W-1:0]    i1_matrix = '0;
    logic            i1_ready = 1'b0;
    logic            o1_busy, o1_valid, o1_last, o1_done;
    logic [W-1:0]    o1_data;
    logic [0:0]      o1_row, o1_col;

    int checks = 0;
    int errors = 0;
    beat_t sb[$];
    vec_t tbl[5];

    localparam logic [FLAT-1:0] T1 = {16'd2, 16'd1, 16'd3, 16'd3, 16'd1, 16'd0};
    localparam logic [FLAT-1:0] MA = {16'hF00F, 16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001};
    localparam logic [FLAT-1:0] MB = {16'h5555, 16'h0F0F, 16'hC3C3, 16'h3C3C, 16'hF0F0, 16'hAAAA};
    localparam logic [FLAT-1:0] MC = {16'h0600, 16'h0500, 16'h0400, 16'h0300, 16'h0200, 16'h0100};
    localparam logic [FLAT-1:0] GH = {6{16'hDEAD}};

    always #5 clk = ~clk;

    matrix_stream_tx #(.MATRIX_SIZE_M(M), .MATRIX_SIZE_N(N), .DATA_WIDTH(W)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_load(i_load), .i_matrix(i_matrix),
        .o_busy(o_busy), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_row(o_row), .o_col(o_col), .o_last(o_last), .o_done(o_done)
    );

    matrix_stream_tx #(.MATRIX_SIZE_M(1), .MATRIX_SIZE_N(1), .DATA_WIDTH(W)) dut1 (
        .i_clk(clk), .i_rst(i_rst), .i_load(i1_load), .i_matrix(i1_matrix),
        .o_busy(o1_busy), .o_valid(o1_valid), .i_ready(i1_ready), .o_data(o1_data),
        .o_row(o1_row), .o_col(o1_col), .o_last(o1_last), .o_done(o1_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t model_beat(input logic [FLAT-1:0] mat, input int k);
        beat_t b;
        int r;
        int c;
`ifdef MATRIX_STREAM_TRANSPOSE_EN
        r = k % M;
        c = k / M;
`else
        r = k / N;
        c = k % N;
`endif
        b.data = mat[(r * N + c) * W +: W];
        b.row  = r[1:0];
        b.col  = c[0:0];
        b.last = (k == M * N - 1);
        return b;
    endfunction

    // Called at a negedge; drives the load immediately and streams to completion.
    task automatic run_stream(input vec_t v);
        beat_t b;
        beat_t hold;
        bit    held = 0;
        bit    fin = 0;
        bit    fin_pending = 0;
        bit    rdy;
        int    sc = 0;
        int    nb = 0;
        int    guard = 0;
        for (int k = 0; k < M * N; k++) sb.push_back(model_beat(v.mat, k));
        i_matrix = v.mat;
        i_load   = 1'b1;
        @(negedge clk);
        i_load   = 1'b0;
        i_matrix = v.ghost ? GH : '1;
        chk("first_valid", o_valid, 1);
        chk("busy_send", o_busy, 1);
        chk("done_low", o_done, 0);
        while (!fin && guard < 200) begin
            guard++;
            if (!o_valid) begin
                chk("valid_in_send", o_valid, 1);
                guard = 200;
            end else begin
                sc++;
                if (held) begin
                    chk("hold_data", o_data, hold.data);
                    chk("hold_row", o_row, hold.row);
                    chk("hold_col", o_col, hold.col);
                    chk("hold_last", o_last, hold.last);
                    held = 0;
                end
                case (v.mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (sc % 2 == 0);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                i_ready = rdy;
                if (rdy) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow: extra beat data %0h", o_data);
                        guard = 200;
                    end else begin
                        b = sb.pop_front();
                        chk("beat_data", o_data, b.data);
                        chk("beat_row", o_row, b.row);
                        chk("beat_col", o_col, b.col);
                        chk("beat_last", o_last, b.last);
                        if (nb == 0) chk("first_data", o_data, v.exp_first);
                        if (b.last) begin
                            chk("last_data", o_data, v.exp_last);
                            fin_pending = 1;
                        end
                    end
                    nb++;
                end else begin
                    hold.data = o_data;
                    hold.row  = o_row;
                    hold.col  = o_col;
                    hold.last = o_last;
                    held      = 1;
                end
                i_load = v.ghost && (sc == 2 || fin_pending);
            end
            @(negedge clk);
            i_load = 1'b0;
            if (fin_pending) begin
                fin = 1;
                chk("done_pulse", o_done, 1);
                chk("valid_after", o_valid, 0);
                chk("busy_after", o_busy, 0);
                chk("last_after", o_last, 0);
            end
        end
        i_ready = 1'b0;
        if (!fin) chk("stream_timeout", 0, 1);
        if (v.exp_cyc > 0) chk("send_cycles", sc, v.exp_cyc);
        chk("beat_count", nb, M * N);
        chk("sb_left", sb.size(), 0);
    endtask

    initial begin
        beat_t b4;
        tbl[0] = '{mat: T1, mode: 0, ghost: 0, chain: 0, exp_cyc: 6,  exp_first: 16'd0,    exp_last: 16'd2};
        tbl[1] = '{mat: T1, mode: 1, ghost: 0, chain: 0, exp_cyc: 12, exp_first: 16'd0,    exp_last: 16'd2};
        tbl[2] = '{mat: MA, mode: 0, ghost: 1, chain: 0, exp_cyc: 6,  exp_first: 16'h0001, exp_last: 16'hF00F};
        tbl[3] = '{mat: MB, mode: 0, ghost: 0, chain: 1, exp_cyc: 6,  exp_first: 16'hAAAA, exp_last: 16'h5555};
        tbl[4] = '{mat: MC, mode: 2, ghost: 0, chain: 0, exp_cyc: 0,  exp_first: 16'h0100, exp_last: 16'h0600};

        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_last", o_last, 0);
        chk("rst_done", o_done, 0);
        chk("rst_data", o_data, 0);
        chk("rst_row", o_row, 0);
        chk("rst_col", o_col, 0);
        i_rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            if (!tbl[i].chain) begin
                @(negedge clk);
                chk("done_one_cycle", o_done, 0);
            end
            run_stream(tbl[i]);
        end

        // Reset in the middle of a stream: abort, no done, restart from (0,0).
        @(negedge clk);
        i_matrix = T1;
        i_load   = 1'b1;
        @(negedge clk);
        i_load  = 1'b0;
        i_ready = 1'b1;
        repeat (3) @(negedge clk);
        b4 = model_beat(T1, 3);
        chk("mid_data", o_data, b4.data);
        chk("mid_row", o_row, b4.row);
        chk("mid_col", o_col, b4.col);
        i_ready = 1'b0;
        i_rst   = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        chk("abort_busy", o_busy, 0);
        chk("abort_valid", o_valid, 0);
        chk("abort_last", o_last, 0);
        chk("abort_done", o_done, 0);
        chk("abort_data", o_data, 0);
        chk("abort_row", o_row, 0);
        chk("abort_col", o_col, 0);
        @(negedge clk);
        chk("abort_no_done", o_done, 0);
        run_stream(tbl[0]);

        // Single-element matrix.
        @(negedge clk);
        i1_matrix = 16'hBEEF;
        i1_load   = 1'b1;
        @(negedge clk);
        i1_load   = 1'b0;
        i1_matrix = 16'h0000;
        chk("one_valid", o1_valid, 1);
        chk("one_data", o1_data, 16'hBEEF);
        chk("one_last", o1_last, 1);
        chk("one_row", o1_row, 0);
        chk("one_col", o1_col, 0);
        chk("one_done_early", o1_done, 0);
        i1_ready = 1'b1;
        @(negedge clk);
        i1_ready = 1'b0;
        chk("one_done", o1_done, 1);
        chk("one_valid_after", o1_valid, 0);
        chk("one_busy_after", o1_busy, 0);
        chk("one_last_after", o1_last, 0);
        @(negedge clk);
        chk("one_done_pulse", o1_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
